// File: rtl/stopwatch_counter.sv
// Five-digit BCD stopwatch (M:SS.hh) driven by a prescaled sys_clk, with display latch.
// Optional macro STOPWATCH_SATURATE_EN: hold at 9:59.99 instead of wrapping.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned PRE_W    = 24
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        count_init,
    input  logic        count_enb,
    input  logic        latch_count,
    output logic [19:0] run_bcd,
    output logic [19:0] disp_bcd,
    output logic        tick,
    output logic        running,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [19:0]      run_q, run_d, disp_q, disp_d, inc_val;
    logic             tick_q, tick_d, ovf_q, ovf_d;
    logic             c1, c2, c3, c4, at_max;

    // Ripple-carry BCD increment; each digit wraps by explicit compare.
    always_comb begin
        c1      = (run_q[3:0]   == 4'd9);
        c2      = c1 && (run_q[7:4]   == 4'd9);
        c3      = c2 && (run_q[11:8]  == 4'd9);
        c4      = c3 && (run_q[15:12] == 4'd5);
        at_max  = c4 && (run_q[19:16] == 4'd9);
        inc_val = run_q;
        inc_val[3:0] = c1 ? 4'd0 : run_q[3:0] + 4'd1;
        if (c1) inc_val[7:4]   = c2 ? 4'd0 : run_q[7:4]   + 4'd1;
        if (c2) inc_val[11:8]  = c3 ? 4'd0 : run_q[11:8]  + 4'd1;
        if (c3) inc_val[15:12] = c4 ? 4'd0 : run_q[15:12] + 4'd1;
        if (c4) inc_val[19:16] = at_max ? 4'd0 : run_q[19:16] + 4'd1;
`ifdef STOPWATCH_SATURATE_EN
        if (at_max) inc_val = run_q;
`else
`endif
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            run_q   <= '0;
            disp_q  <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            run_q   <= run_d;
            disp_q  <= disp_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (count_init)           state_d = IDLE;
        else if (count_enb)       state_d = RUN;
        else if (state_q == RUN)  state_d = PAUSED;
    end

    // Latch samples the pre-edge run value, so it sees the time before any clear/increment.
    always_comb begin
        pre_d  = pre_q;
        run_d  = run_q;
        tick_d = 1'b0;
        ovf_d  = ovf_q;
        disp_d = latch_count ? run_q : disp_q;
        if (count_init) begin
            pre_d = '0;
            run_d = '0;
            ovf_d = 1'b0;
        end else if (count_enb) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                run_d  = inc_val;
                if (at_max) ovf_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_comb begin
        running  = (state_q == RUN);
        run_bcd  = run_q;
        disp_bcd = disp_q;
        tick     = tick_q;
        overflow = ovf_q;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- BCD elapsed-time counter that sits directly downstream of the stopwatch trigger detector.
- Consumes the detector's count_init, count_enb and latch_count strobes.
- Advances a five-digit M:SS.hh time value from a prescaled sys_clk.
- Holds a latched copy for the display driver, plus run-state and overflow status.

Parameters:
- TICK_DIV, 500000, sys_clk cycles per hundredth-second tick (50 MHz default); legal range 2 to 2^24-1.
- PRE_W, 24, prescaler counter width; must hold TICK_DIV-1.

Ports:
- sys_clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- count_init  input  1  synchronous clear of time value and prescaler.
- count_enb  input  1  level; counting advances while high.
- latch_count  input  1  single-cycle strobe; copies running time into display register.
- run_bcd  output  20  live time {min[3:0], sec_t[3:0], sec_u[3:0], hund_t[3:0], hund_u[3:0]}.
- disp_bcd  output  20  latched time, same packing.
- tick  output  1  one-cycle pulse on each hundredth increment.
- running  output  1  high in state RUN.
- overflow  output  1  sticky wrap/saturation flag.

Behaviour:
- Reset (async, reset_n=0): run_bcd=0, disp_bcd=0, prescaler=0, tick=0, running=0, overflow=0, state=IDLE.
- States:
  - IDLE: time is zero.
  - RUN: count_enb high.
  - PAUSED: stopped with nonzero time.
- Transitions, evaluated each edge, count_init highest priority:
  - count_init=1: next state IDLE.
  - Else count_enb=1: next state RUN.
  - Else from RUN: PAUSED.
  - Otherwise hold.
- count_init=1:
  - Next edge: run_bcd=0, prescaler=0, overflow=0, tick=0.
  - No increment that cycle even if count_enb=1.
- Prescaler:
  - In RUN or with count_enb=1 (and no init), prescaler increments each cycle.
  - At TICK_DIV-1 it wraps to 0 and asserts tick for that same edge's output cycle.
  - First tick after init occurs exactly TICK_DIV enabled cycles later.
  - count_enb=0 freezes the prescaler (no reset), so pause/resume loses no partial tick.
- Digit chain (ripple carry, all updated on the tick edge):
  - hund_u 0-9, then hund_t 0-9, then sec_u 0-9, then sec_t 0-5, then min 0-9.
  - Max value 9:59.99 (BCD 0x95999).
  - Increment from max wraps to 0:00.00 and sets overflow=1.
  - overflow stays set until count_init or reset.
- Latch:
  - latch_count=1 loads disp_bcd with run_bcd as registered before that edge (pre-increment, pre-clear).
  - Simultaneous latch_count and count_init captures the final time, then clears run_bcd.
  - disp_bcd is otherwise held, and is unaffected by count_init.
- running = (state==RUN), registered.
- Output latency:
  - run_bcd changes on the tick edge.
  - disp_bcd changes on the latch_count edge.
  - Both are visible one cycle after the strobe is sampled.
- Invalid BCD cannot arise; all digit registers use explicit wrap compares, never binary overflow.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined: at 9:59.99 further ticks hold the value at 0x95999 and set overflow; tick still pulses.
- Undefined: wrap to 0x00000 with overflow set, as above.

Test Plan:
- Reset mid-count: TICK_DIV=4, count_enb=1 for 20 cycles, assert reset_n=0 asynchronously between edges -> all outputs 0 immediately, state IDLE.
- Basic count: TICK_DIV=4, count_init pulse, then count_enb=1 for 40 cycles -> 10 tick pulses every 4 cycles, run_bcd=0x00010, running=1 throughout.
- Pause/resume: count_enb=1 for 6 cycles, 0 for 10, 1 for 2 -> exactly 2 ticks total, running drops one cycle after enb falls, state PAUSED then RUN.
- Latch: latch_count pulse when run_bcd=0x00037 with a tick on the same edge -> disp_bcd=0x00037, run_bcd=0x00038; disp_bcd unchanged by a later count_init.
- Carry/overflow: preload by running to 0x95998, two ticks -> 0x95999 then 0x00000 with overflow=1. With STOPWATCH_SATURATE_EN -> stays 0x95999, overflow=1. count_init clears overflow.
- Simultaneous init+enb+latch at run_bcd=0x01234 -> disp_bcd=0x01234, run_bcd=0, prescaler=0, no tick, state IDLE.
